// File: rtl/bcg_pkg.sv
// Shared types and helpers for the Bulls-and-Cows engine: state encoding and score width.
package bcg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PLAY  = 2'd2,
    DONE  = 2'd3
  } bcg_state_t;

  // Width needed to hold a count from 0 to n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bcg_scorer.sv
// Combinational xAyB scorer plus guess validity (digit range and uniqueness).
// Zero latency, no state; validity depends only on the guess.
module bcg_scorer
  import bcg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int BASE       = 10
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0] secret,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] guess,
  output logic [cnt_w(NUM_DIGITS)-1:0]  a,
  output logic [cnt_w(NUM_DIGITS)-1:0]  b,
  output logic                          valid
);

  localparam int CW = cnt_w(NUM_DIGITS);

  logic [DIGIT_W-1:0] s_dig [NUM_DIGITS];
  logic [DIGIT_W-1:0] g_dig [NUM_DIGITS];

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      s_dig[i] = secret[i*DIGIT_W +: DIGIT_W];
      g_dig[i] = guess[i*DIGIT_W +: DIGIT_W];
    end
  end

  // The extra bit keeps the range check correct when BASE == 2**DIGIT_W.
  always_comb begin
    valid = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ({1'b0, g_dig[i]} >= (DIGIT_W+1)'(BASE))
        valid = 1'b0;
      for (int j = i + 1; j < NUM_DIGITS; j++) begin
        if (g_dig[i] == g_dig[j])
          valid = 1'b0;
      end
    end
  end

  always_comb begin
    a = '0;
    b = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (g_dig[i] == s_dig[i])
        a = a + CW'(1);
      else begin
        for (int j = 0; j < NUM_DIGITS; j++) begin
          if (j != i && g_dig[i] == s_dig[j])
            b = b + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/bulls_cows_engine.sv
// Bulls-and-Cows round controller: secret latch, FSM, attempt counter and registered score/verdict.
// One-cycle latency from strobe to outputs; no backpressure, every strobe acts on the edge it is sampled.
module bulls_cows_engine
  import bcg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = 4,
  parameter int BASE        = 10,
  parameter int MAX_GUESSES = 18
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]    code_in,
  input  logic                             set_stb,
  input  logic                             start_stb,
  input  logic                             guess_stb,
  input  logic                             clear_stb,
  output logic [1:0]                       state_o,
  output logic [cnt_w(NUM_DIGITS)-1:0]     a_cnt,
  output logic [cnt_w(NUM_DIGITS)-1:0]     b_cnt,
  output logic                             result_valid,
  output logic                             code_err,
  output logic [$clog2(MAX_GUESSES+1)-1:0] guess_cnt,
  output logic [MAX_GUESSES-1:0]           used_bar,
  output logic                             win,
  output logic                             lose
);

  localparam int CW = cnt_w(NUM_DIGITS);
  localparam int GW = $clog2(MAX_GUESSES + 1);
  localparam int SW = NUM_DIGITS * DIGIT_W;

  bcg_state_t           state_q, state_d;
  logic [SW-1:0]        secret_q, secret_d;
  logic [CW-1:0]        a_q, a_d, b_q, b_d;
  logic                 rv_q, rv_d, err_q, err_d;
  logic [GW-1:0]        gc_q, gc_d;
  logic [MAX_GUESSES-1:0] used_q, used_d;
  logic                 win_q, win_d, lose_q, lose_d;

  logic [CW-1:0]        sc_a, sc_b;
  logic                 sc_valid;

  bcg_scorer #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W),
    .BASE       (BASE)
  ) u_scorer (
    .secret (secret_q),
    .guess  (code_in),
    .a      (sc_a),
    .b      (sc_b),
    .valid  (sc_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      secret_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
      gc_q     <= '0;
      used_q   <= '0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      secret_q <= secret_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
      gc_q     <= gc_d;
      used_q   <= used_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    secret_d = secret_q;
    a_d      = a_q;
    b_d      = b_q;
    rv_d     = 1'b0;
    err_d    = 1'b0;
    gc_d     = gc_q;
    used_d   = used_q;
    win_d    = win_q;
    lose_d   = lose_q;

    // Clear overrides every other strobe; the secret is left stale on purpose.
    if (clear_stb) begin
      state_d = IDLE;
      a_d     = '0;
      b_d     = '0;
      gc_d    = '0;
      used_d  = '0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (set_stb) begin
            if (sc_valid) begin
              secret_d = code_in;
              state_d  = ARMED;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ARMED: begin
          if (start_stb)
            state_d = PLAY;
        end
        PLAY: begin
          if (guess_stb) begin
            if (sc_valid) begin
              a_d    = sc_a;
              b_d    = sc_b;
              rv_d   = 1'b1;
              gc_d   = gc_q + GW'(1);
              used_d = (used_q << 1) | MAX_GUESSES'(1);
              if (sc_a == CW'(NUM_DIGITS)) begin
                win_d   = 1'b1;
                state_d = DONE;
              end else if (gc_q + GW'(1) == GW'(MAX_GUESSES)) begin
                lose_d  = 1'b1;
                state_d = DONE;
              end
            end else begin
              err_d = 1'b1;
            end
          end
        end
        DONE: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign state_o      = state_q;
  assign a_cnt        = a_q;
  assign b_cnt        = b_q;
  assign result_valid = rv_q;
  assign code_err     = err_q;
  assign guess_cnt    = gc_q;
  assign used_bar     = used_q;
  assign win          = win_q;
  assign lose         = lose_q;

endmodule

// File: tb/tb_bulls_cows_engine.sv
// Directed bench for bulls_cows_engine at default parameters with hand-computed expectations.
module tb_bulls_cows_engine;

  logic        clk;
  logic        rst;
  logic [15:0] code_in;
  logic        set_stb, start_stb, guess_stb, clear_stb;
  logic [1:0]  state_o;
  logic [2:0]  a_cnt, b_cnt;
  logic        result_valid, code_err;
  logic [4:0]  guess_cnt;
  logic [17:0] used_bar;
  logic        win, lose;

  int n_chk  = 0;
  int n_fail = 0;

  bulls_cows_engine dut (
    .clk          (clk),
    .rst          (rst),
    .code_in      (code_in),
    .set_stb      (set_stb),
    .start_stb    (start_stb),
    .guess_stb    (guess_stb),
    .clear_stb    (clear_stb),
    .state_o      (state_o),
    .a_cnt        (a_cnt),
    .b_cnt        (b_cnt),
    .result_valid (result_valid),
    .code_err     (code_err),
    .guess_cnt    (guess_cnt),
    .used_bar     (used_bar),
    .win          (win),
    .lose         (lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives the given strobes for exactly one rising edge, returns 1 time unit after it.
  task automatic strobe(input logic s, input logic st, input logic g, input logic c,
                        input logic [15:0] code);
    code_in   = code;
    set_stb   = s;
    start_stb = st;
    guess_stb = g;
    clear_stb = c;
    @(posedge clk);
    #1;
    set_stb   = 1'b0;
    start_stb = 1'b0;
    guess_stb = 1'b0;
    clear_stb = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_a"},     32'(a_cnt), 32'd0);
    check({tag, "_b"},     32'(b_cnt), 32'd0);
    check({tag, "_rv"},    32'(result_valid), 32'd0);
    check({tag, "_err"},   32'(code_err), 32'd0);
    check({tag, "_gc"},    32'(guess_cnt), 32'd0);
    check({tag, "_used"},  32'(used_bar), 32'd0);
    check({tag, "_win"},   32'(win), 32'd0);
    check({tag, "_lose"},  32'(lose), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    code_in   = '0;
    set_stb   = 1'b0;
    start_stb = 1'b0;
    guess_stb = 1'b0;
    clear_stb = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("reset");
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Scenario 1: basic score
    strobe(1, 0, 0, 0, 16'h1234);
    check("s1_armed", 32'(state_o), 32'd1);
    strobe(0, 0, 1, 0, 16'h5678);
    check("s1_armed_guess_ignored", 32'(result_valid), 32'd0);
    strobe(0, 1, 0, 0, 16'h0000);
    check("s1_play", 32'(state_o), 32'd2);
    strobe(0, 0, 1, 0, 16'h1243);
    check("s1_rv", 32'(result_valid), 32'd1);
    check("s1_a", 32'(a_cnt), 32'd2);
    check("s1_b", 32'(b_cnt), 32'd2);
    check("s1_gc", 32'(guess_cnt), 32'd1);
    check("s1_used", 32'(used_bar), 32'h00001);
    @(posedge clk);
    #1;
    check("s1_rv_drop", 32'(result_valid), 32'd0);
    check("s1_a_hold", 32'(a_cnt), 32'd2);

    // Scenario 2: all cows, then win
    strobe(0, 0, 0, 1, 16'h0000);
    check_all_zero("s2_clear");
    strobe(1, 0, 0, 0, 16'h1234);
    strobe(0, 1, 0, 0, 16'h0000);
    strobe(0, 0, 1, 0, 16'h4321);
    check("s2_a0", 32'(a_cnt), 32'd0);
    check("s2_b4", 32'(b_cnt), 32'd4);
    strobe(0, 0, 1, 0, 16'h1234);
    check("s2_a4", 32'(a_cnt), 32'd4);
    check("s2_b0", 32'(b_cnt), 32'd0);
    check("s2_win", 32'(win), 32'd1);
    check("s2_lose", 32'(lose), 32'd0);
    check("s2_state", 32'(state_o), 32'd3);
    check("s2_gc", 32'(guess_cnt), 32'd2);
    check("s2_used", 32'(used_bar), 32'h00003);
    strobe(0, 0, 1, 0, 16'h5678);
    check("s2_done_rv", 32'(result_valid), 32'd0);
    check("s2_done_gc", 32'(guess_cnt), 32'd2);
    check("s2_done_win", 32'(win), 32'd1);

    // Scenario 3: rejected codes
    strobe(0, 0, 0, 1, 16'h0000);
    strobe(1, 0, 0, 0, 16'h1123);
    check("s3_dup_err", 32'(code_err), 32'd1);
    check("s3_dup_state", 32'(state_o), 32'd0);
    strobe(1, 0, 0, 0, 16'h12A4);
    check("s3_range_err", 32'(code_err), 32'd1);
    check("s3_range_state", 32'(state_o), 32'd0);
    strobe(1, 0, 0, 0, 16'h1234);
    check("s3_good_err", 32'(code_err), 32'd0);
    check("s3_good_state", 32'(state_o), 32'd1);
    strobe(0, 1, 0, 0, 16'h0000);
    strobe(0, 0, 1, 0, 16'h5567);
    check("s3_guess_err", 32'(code_err), 32'd1);
    check("s3_guess_rv", 32'(result_valid), 32'd0);
    check("s3_guess_gc", 32'(guess_cnt), 32'd0);
    check("s3_guess_state", 32'(state_o), 32'd2);

    // Scenario 4: exhaust the attempts
    for (int k = 1; k <= 18; k++) begin
      strobe(0, 0, 1, 0, 16'h5678);
      check("s4_rv", 32'(result_valid), 32'd1);
      check("s4_a", 32'(a_cnt), 32'd0);
      check("s4_b", 32'(b_cnt), 32'd0);
      check("s4_gc", 32'(guess_cnt), 32'(k));
      check("s4_state", 32'(state_o), (k == 18) ? 32'd3 : 32'd2);
      check("s4_lose", 32'(lose), (k == 18) ? 32'd1 : 32'd0);
    end
    check("s4_used", 32'(used_bar), 32'h3FFFF);
    check("s4_win", 32'(win), 32'd0);
    strobe(0, 0, 1, 0, 16'h1234);
    check("s4_after_rv", 32'(result_valid), 32'd0);
    check("s4_after_gc", 32'(guess_cnt), 32'd18);
    check("s4_after_win", 32'(win), 32'd0);
    check("s4_after_state", 32'(state_o), 32'd3);

    // Scenario 5: clear wins over a simultaneous guess
    strobe(0, 0, 0, 1, 16'h0000);
    strobe(1, 0, 0, 0, 16'h9870);
    strobe(0, 1, 0, 0, 16'h0000);
    for (int k = 0; k < 5; k++)
      strobe(0, 0, 1, 0, 16'h0789);
    check("s5_gc5", 32'(guess_cnt), 32'd5);
    check("s5_a", 32'(a_cnt), 32'd0);
    check("s5_b", 32'(b_cnt), 32'd4);
    strobe(0, 0, 1, 1, 16'h9870);
    check("s5_state", 32'(state_o), 32'd0);
    check("s5_gc", 32'(guess_cnt), 32'd0);
    check("s5_rv", 32'(result_valid), 32'd0);
    check("s5_win", 32'(win), 32'd0);
    check("s5_used", 32'(used_bar), 32'd0);

    // Scenario 6: asynchronous reset mid-round
    strobe(1, 0, 0, 0, 16'h1234);
    strobe(0, 1, 0, 0, 16'h0000);
    strobe(0, 0, 1, 0, 16'h1235);
    check("s6_pre_a", 32'(a_cnt), 32'd3);
    #2 rst = 1'b1;
    #1;
    check_all_zero("s6_async");
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    strobe(0, 1, 0, 0, 16'h0000);
    check("s6_start_ignored", 32'(state_o), 32'd0);
    strobe(1, 0, 0, 0, 16'h1234);
    check("s6_set", 32'(state_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
